// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result bundle for nibble_serial_adder.
// master: producer/consumer side; slave: the adder. ovf only with NSA_SIGNED_OVF_EN.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef NSA_SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, c_in, out_ready,
`ifdef NSA_SIGNED_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, s, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
`ifdef NSA_SIGNED_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, s, c_out
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice, one nibble per clock.
// Ports: clk, rst (async, active-high), bus (slave: in_valid/in_ready, a, b,
// c_in, out_valid/out_ready, s, c_out, ovf when NSA_SIGNED_OVF_EN defined).
// WIDTH must be a multiple of 4 and at least 4.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             c_out_q;
    logic [3:0]       nib_sum;
    logic             nib_co;
    logic             accept;
    logic             last;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (k_q == KW'(NIB - 1));

    // Operands shift right so the slice always sees the current nibble
    // in the low four bits.
    ripple_carry_adder u_slice (
        .a   (a_q[3:0]),
        .b   (b_q[3:0]),
        .ci  (carry_q),
        .sum (nib_sum),
        .co  (nib_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = ADD;
            ADD:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            k_q     <= '0;
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.c_in;
        end else if (state_q == ADD) begin
            a_q                      <= a_q >> 4;
            b_q                      <= b_q >> 4;
            s_q[{k_q, 2'b00} +: 4]   <= nib_sum;
            carry_q                  <= nib_co;
            k_q                      <= k_q + 1'b1;
            if (last) begin
                c_out_q <= nib_co;
            end
        end
    end

`ifdef NSA_SIGNED_OVF_EN
    logic ovf_q;
    logic c_into_msb;

    // Carry into the slice's top bit, recovered from its sum bit.
    assign c_into_msb = a_q[3] ^ b_q[3] ^ nib_sum[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == ADD && last) begin
            ovf_q <= c_into_msb ^ nib_co;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Directed vector table plus stall, async reset and back-to-back sequences.
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic get_ovf();
`ifdef NSA_SIGNED_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timeout(name);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, output logic [15:0] s,
                          output logic co, output logic ov,
                          output int lat);
        wait_ready("op_in_ready");
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) timeout("op_out_valid");
        s  = bus.s;
        co = bus.c_out;
        ov = get_ovf();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        if (!bus.out_valid) timeout(name);
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc;
        logic        rv;
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rci;
        logic [16:0] exp17;
        int          acc;
        int          prev;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_c_out", 32'(bus.c_out), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, rs, rc, rv, lat);
            chk($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].s));
            chk($sformatf("vec%0d_c", i), 32'(rc), 32'(vecs[i].co));
            chk($sformatf("vec%0d_lat", i), 32'(lat), NIB);
`ifdef NSA_SIGNED_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(rv), 32'(vecs[i].ov));
`endif
        end

        // Stall in DONE with new operands offered.
        wait_ready("stall_ready");
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out_valid("stall_out_valid");
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.c_in     = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_s", 32'(bus.s), 32'h3333);
            chk("stall_c", 32'(bus.c_out), 0);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_out_valid", 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_idle", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("stall_accept", 32'(bus.in_ready), 0);
        wait_out_valid("stall2_out_valid");
        chk("stall2_s", 32'(bus.s), 32'h0000);
        chk("stall2_c", 32'(bus.c_out), 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Asynchronous reset during the second ADD cycle.
        wait_ready("rst_ready");
        bus.a        = 16'h9999;
        bus.b        = 16'h1111;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_nib0", 32'(bus.s[3:0]), 32'hA);
        #1 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_s", 32'(bus.s), 0);
        chk("arst_c_out", 32'(bus.c_out), 0);
`ifdef NSA_SIGNED_OVF_EN
        chk("arst_ovf", 32'(bus.ovf), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, rv, lat);
        chk("post_rst_s", 32'(rs), 32'h0100);
        chk("post_rst_c", 32'(rc), 0);
        chk("post_rst_lat", 32'(lat), NIB);

        // Back-to-back with both handshakes held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev = 0;
        for (int i = 0; i < 50; i++) begin
            wait_ready("b2b_ready");
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rci = 1'($urandom_range(0, 1));
            bus.a    = ra;
            bus.b    = rb;
            bus.c_in = rci;
            acc = cyc;
            if (i > 0) chk("b2b_spacing", 32'(acc - prev), NIB + 2);
            prev = acc;
            @(posedge clk);
            wait_out_valid("b2b_out_valid");
            exp17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rci};
            chk("b2b_s", 32'(bus.s), 32'(exp17[15:0]));
            chk("b2b_c", 32'(bus.c_out), 32'(exp17[16]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
